// File: rtl/alu_decoder.sv
// alu_decoder: RV32I OP/OP-IMM decoder behind a 2-entry skid buffer.
// Define ALU_DECODER_SHAMT_CHECK_EN to flag bad shift-immediate funct7.
module alu_decoder #(
  parameter int PASS_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_func3,
  output logic        out_subsra,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic        out_use_imm,
  output logic        out_illegal,
  output logic [7:0]  illegal_cnt
);

  typedef struct packed {
    logic [2:0]  func3;
    logic        subsra;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } dec_t;

  dec_t       dec;
  dec_t       out_q, out_d;
  dec_t       skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q, in_ready_d;
  logic [7:0] cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] f3;
  logic       is_op;
  logic       is_opi;
  logic       op_ok;
  logic       shamt_bad;
  logic       accept;
  logic       enq;
  logic       drain;

  assign opcode = in_instr[6:0];
  assign funct7 = in_instr[31:25];
  assign f3     = in_instr[14:12];
  assign is_op  = (opcode == 7'b0110011);
  assign is_opi = (opcode == 7'b0010011);

  assign op_ok = (funct7 == 7'b0000000)
    || ((funct7 == 7'b0100000)
        && ((f3 == 3'b000) || (f3 == 3'b101)));

`ifdef ALU_DECODER_SHAMT_CHECK_EN
  assign shamt_bad =
    ((f3 == 3'b001) && (funct7 != 7'b0000000))
    || ((f3 == 3'b101)
        && (funct7 != 7'b0000000)
        && (funct7 != 7'b0100000));
`else
  assign shamt_bad = 1'b0;
`endif

  // Decode the offered word into an ALU command.
  always_comb begin
    dec         = '0;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    dec.illegal = 1'b1;
    unique case (1'b1)
      is_op: begin
        dec.func3   = f3;
        dec.subsra  = in_instr[30];
        dec.illegal = !op_ok;
      end
      is_opi: begin
        dec.func3   = f3;
        dec.use_imm = 1'b1;
        dec.rs2     = 5'd0;
        dec.illegal = shamt_bad;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.imm    = {27'd0, in_instr[24:20]};
          dec.subsra = (f3 == 3'b101) && in_instr[30];
        end else begin
          dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      default: ;
    endcase
  end

  assign accept = in_valid && in_ready_q;
  assign enq    = accept
    && (!dec.illegal || (PASS_ILLEGAL != 0));
  assign drain  = out_valid_q && out_ready;

  // Skid buffer next state: EMPTY / ONE / FULL.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q) begin
      if (enq) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      if (drain) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else begin
      if (drain && enq) begin
        out_d = dec;
      end else if (drain) begin
        out_valid_d = 1'b0;
      end else if (enq) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
    in_ready_d = !skid_valid_d;
  end

  // Saturating count of accepted illegal words.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec.illegal && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State registers; reset empties both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= 8'd0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_func3   = out_q.func3;
  assign out_subsra  = out_q.subsra;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_use_imm = out_q.use_imm;
  assign out_illegal = out_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule
